program_loader: RTL and testbench

//  Upstream boot stage for the proc2 processor and its RAM. Receives a framed byte stream, assembles
//  16-bit words, writes them into processor RAM from BASE_ADDR, verifies an XOR checksum, then

---
 rtl/loader_pkg.sv | 31 +++
 rtl/loader_word_assembler.sv | 42 ++++
 rtl/program_loader.sv | 108 ++++++++++
 tb/tb_program_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states in frame-field order and
// the fixed byte/word/length widths.
package loader_pkg;

  localparam int unsigned ByteW       = 8;
  localparam int unsigned WordW       = 16;
  localparam int unsigned LenW        = 16;
  // One extra bit so the word index can reach N itself without wrapping.
  localparam int unsigned CntW        = LenW + 1;
  localparam int unsigned DefMaxWords = 256;

  // Enumerator order follows the frame: length bytes, word bytes, write, checksum.
  typedef enum logic [3:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDatHi,
    StDatLo,
    StWrite,
    StCheck,
    StRun,
    StError
  } state_e;

  // States in which the loader is waiting for a stream byte.
  function automatic logic is_rx_state(state_e s);
    return (s == StLenHi) || (s == StLenLo) || (s == StDatHi) || (s == StDatLo) ||
           (s == StCheck);
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Pairs stream bytes into 16-bit words and keeps the running XOR of the covered frame bytes.
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clear,
  input  logic             hi_load,
  input  logic             lo_load,
  input  logic             chk_load,
  input  logic [ByteW-1:0] byte_data,
  output logic [WordW-1:0] pair,
  output logic [WordW-1:0] word,
  output logic [ByteW-1:0] chk
);

  logic [ByteW-1:0] hi_q;
  logic [WordW-1:0] word_q;
  logic [ByteW-1:0] chk_q;

  // Live {high byte, current byte}; used for the length field as well as data words.
  assign pair = {hi_q, byte_data};
  assign word = word_q;
  assign chk  = chk_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hi_q   <= '0;
      word_q <= '0;
      chk_q  <= '0;
    end else begin
      if (hi_load) hi_q <= byte_data;
      if (lo_load) word_q <= {hi_q, byte_data};
      if (clear) begin
        chk_q <= '0;
      end else if (chk_load) begin
        chk_q <= chk_q ^ byte_data;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader for proc2: receives a length-prefixed word frame, writes it to RAM from BASE_ADDR,
// verifies the XOR checksum and then releases the CPU.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = DefMaxWords
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr,
  output logic              cpu_hold,
  output logic              Run,
  output logic              load_done,
  output logic              load_err
);

  state_e          state_q, state_d;
  logic [LenW-1:0] len_q;
  logic [CntW-1:0] idx_q, idx_next;
  logic [WordW-1:0] pair;
  logic [ByteW-1:0] chk;
  logic            accept;
  logic            restart;

  assign accept   = byte_valid & byte_ready;
  assign idx_next = idx_q + 1'b1;
  // start only takes effect when no load is in progress.
  assign restart  = start & ((state_q == StIdle) || (state_q == StRun) || (state_q == StError));

  loader_word_assembler u_asm (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear    (restart),
    .hi_load  (accept & ((state_q == StLenHi) || (state_q == StDatHi))),
    .lo_load  (accept & (state_q == StDatLo)),
    .chk_load (accept & ((state_q == StLenHi) || (state_q == StLenLo) ||
                         (state_q == StDatHi) || (state_q == StDatLo))),
    .byte_data(byte_data),
    .pair     (pair),
    .word     (mem_data),
    .chk      (chk)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRun, StError: if (start) state_d = StLenHi;
      StLenHi: if (accept) state_d = StLenLo;
      StLenLo: begin
        if (accept) begin
          if (pair == '0) begin
            state_d = StCheck;
          end else if (32'(pair) > MAX_WORDS) begin
            state_d = StError;
          end else begin
            state_d = StDatHi;
          end
        end
      end
      StDatHi: if (accept) state_d = StDatLo;
      StDatLo: if (accept) state_d = StWrite;
      StWrite: state_d = (idx_next == {1'b0, len_q}) ? StCheck : StDatHi;
      StCheck: if (accept) state_d = (byte_data == chk) ? StRun : StError;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      idx_q      <= '0;
      mem_addr   <= '0;
      byte_ready <= 1'b0;
      mem_wr     <= 1'b0;
      cpu_hold   <= 1'b1;
      Run        <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_ready <= is_rx_state(state_d);
      mem_wr     <= (state_d == StWrite);
      cpu_hold   <= (state_d != StRun);
      Run        <= (state_d == StRun);
      load_done  <= (state_d == StRun);
      load_err   <= (state_d == StError);
      if (restart) begin
        idx_q <= '0;
      end else if (state_q == StWrite) begin
        idx_q <= idx_next;
      end
      if (accept && (state_q == StLenLo)) len_q <= pair;
      if (accept && (state_q == StDatLo)) mem_addr <= BASE_ADDR + ADDR_W'(idx_q);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: frames are parsed by a byte-level reference model and the
// observed RAM writes, accepted byte count and final flags are compared against it.
module tb_program_loader;

  localparam int unsigned MaxWords = 256;
  localparam logic [15:0] Base     = 16'h0000;

  logic        Clock = 1'b0;
  logic        Reset, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_wr, cpu_hold, Run, load_done, load_err;
  logic [15:0] mem_addr, mem_data;

  program_loader #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .BASE_ADDR(Base),
    .MAX_WORDS(MaxWords)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_wr    (mem_wr),
    .cpu_hold  (cpu_hold),
    .Run       (Run),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 Clock = ~Clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          pulse_at = -1;
  logic [7:0]  frame[$];
  logic [31:0] wr_log[$];
  logic [31:0] exp_wr[$];
  logic        exp_run;
  int          exp_acc;

  always @(negedge Clock) if (mem_wr === 1'b1) wr_log.push_back({mem_addr, mem_data});

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] xor_all();
    logic [7:0] r = 8'h00;
    foreach (frame[i]) r ^= frame[i];
    return r;
  endfunction

  // Expected behaviour of one frame, straight from the frame format.
  task automatic model();
    int         n;
    logic [7:0] c;
    exp_wr.delete();
    n = int'({frame[0], frame[1]});
    if (n > int'(MaxWords)) begin
      exp_run = 1'b0;
      exp_acc = 2;
      return;
    end
    c = 8'h00;
    for (int i = 0; i < 2 + 2 * n; i++) c ^= frame[i];
    for (int w = 0; w < n; w++) exp_wr.push_back({Base + 16'(w), frame[2+2*w], frame[3+2*w]});
    exp_acc = 2 * n + 3;
    exp_run = (frame[2+2*n] == c);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".byte_ready"}, 32'(byte_ready), 0);
    check_eq({tag, ".mem_addr"}, 32'(mem_addr), 0);
    check_eq({tag, ".mem_data"}, 32'(mem_data), 0);
    check_eq({tag, ".mem_wr"}, 32'(mem_wr), 0);
    check_eq({tag, ".cpu_hold"}, 32'(cpu_hold), 1);
    check_eq({tag, ".Run"}, 32'(Run), 0);
    check_eq({tag, ".load_done"}, 32'(load_done), 0);
    check_eq({tag, ".load_err"}, 32'(load_err), 0);
  endtask

  task automatic pulse_start();
    @(negedge Clock) start = 1'b1;
    @(negedge Clock) start = 1'b0;
  endtask

  // Offers the frame bytes with random bubbles; returns how many were transferred.
  task automatic send(input int pct, input int budget, output int sent);
    int i   = 0;
    int cyc = 0;
    while (i < frame.size() && cyc < budget) begin
      @(negedge Clock);
      cyc++;
      start      = (i == pulse_at);
      byte_valid = ($urandom_range(0, 99) < pct);
      byte_data  = frame[i];
      if (byte_valid && byte_ready) i++;
    end
    @(negedge Clock);
    byte_valid = 1'b0;
    start      = 1'b0;
    sent       = i;
  endtask

  task automatic run_frame(input string tag, input int pct);
    int sent;
    model();
    pulse_start();
    check_eq({tag, ".start_run"}, 32'(Run), 0);
    check_eq({tag, ".start_hold"}, 32'(cpu_hold), 1);
    check_eq({tag, ".start_flags"}, 32'({load_done, load_err}), 0);
    check_eq({tag, ".start_ready"}, 32'(byte_ready), 1);
    wr_log.delete();
    send(pct, 10 * frame.size() + 40, sent);
    check_eq({tag, ".accepted"}, 32'(sent), 32'(exp_acc));
    check_eq({tag, ".Run"}, 32'(Run), 32'(exp_run));
    check_eq({tag, ".load_done"}, 32'(load_done), 32'(exp_run));
    check_eq({tag, ".load_err"}, 32'(load_err), 32'(!exp_run));
    check_eq({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(!exp_run));
    check_eq({tag, ".byte_ready"}, 32'(byte_ready), 0);
    check_eq({tag, ".n_writes"}, 32'(wr_log.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      check_eq({tag, ".write"}, (i < wr_log.size()) ? wr_log[i] : 32'hxxxx_xxxx, exp_wr[i]);
  endtask

  task automatic load_frame1(input logic [7:0] chk);
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    frame.push_back(chk);
  endtask

  initial begin
    int sent;
    logic [7:0] c;
    Reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge Clock);
    check_reset_outputs("por");
    Reset = 1'b0;

    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    c = xor_all();
    load_frame1(c);
    run_frame("frame1", 100);
    load_frame1(8'h00);
    run_frame("bad_chk", 100);
    frame = '{8'h00, 8'h00, 8'h00};
    run_frame("empty", 100);
    frame = '{8'h01, 8'h01, 8'h12, 8'h34, 8'h56};
    run_frame("too_long", 100);

    load_frame1(c);
    pulse_at = 3;
    run_frame("bubbles_mid_start", 40);
    pulse_at = -1;

    // Asynchronous reset part-way through a load.
    pulse_start();
    frame = '{8'h00, 8'h02, 8'h12};
    wr_log.delete();
    send(100, 40, sent);
    #2 Reset = 1'b1;
    #1 check_reset_outputs("mid_reset");
    check_eq("mid_reset.no_write", 32'(wr_log.size()), 0);
    @(negedge Clock) Reset = 1'b0;
    load_frame1(c);
    run_frame("after_reset", 100);
    run_frame("restart_from_run", 70);

    // Length boundary: exactly MaxWords is legal, one more is not.
    frame.delete();
    frame.push_back(8'(MaxWords >> 8));
    frame.push_back(8'(MaxWords));
    repeat (2 * MaxWords) frame.push_back(8'($urandom));
    frame.push_back(xor_all());
    run_frame("max_words", 100);
    frame = '{8'(MaxWords >> 8), 8'(MaxWords + 1), 8'h00, 8'h00, 8'h00};
    run_frame("max_plus_one", 100);

    for (int t = 0; t < 12; t++) begin
      int n;
      int kind;
      kind = $urandom_range(0, 9);
      frame.delete();
      if (kind == 0) begin
        n = $urandom_range(MaxWords + 1, 1000);
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        repeat (3) frame.push_back(8'($urandom));
      end else begin
        n = $urandom_range(0, 8);
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        repeat (2 * n) frame.push_back(8'($urandom));
        c = xor_all();
        if (kind == 1) c ^= 8'(1 << $urandom_range(0, 7));
        frame.push_back(c);
      end
      run_frame("rand", $urandom_range(30, 100));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
